// File: rtl/pmod_cmd_parser.sv
// Host command parser: turns a Pmod byte stream into AXI bus-master write/read requests
// and streams acks/read data back. Optional inter-byte timeout enabled by CMD_TIMEOUT_EN.
module pmod_cmd_parser #(
    parameter int unsigned RFIFO_DEPTH = 16
`ifdef CMD_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1000000
`endif
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESET,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        write_req,
    output logic        write_bus_req,
    output logic        read_req,
    input  logic        busy,
    output logic [9:0]  len,
    output logic [31:0] address,
    output logic [63:0] wdata,
    input  logic [63:0] rdata,
    input  logic        rdata_valid,
    input  logic        rlast,
    output logic        error,
    input  logic        error_clr
);

    typedef enum logic [2:0] {
        IDLE, HDR, WDATA, WBUS, WACK, RREQ, RDATA, ERR
    } state_t;

    localparam int unsigned AW = $clog2(RFIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    state_t        state, next_state;
    logic          rx_fire, tx_fire, timeout;
    logic          is_read;
    logic [2:0]    hdr_idx, byte_cnt, rd_byte;
    logic [7:0]    word_cnt, words_total;
    logic [55:0]   wbuf;
    logic [63:0]   mem [RFIFO_DEPTH];
    logic [63:0]   head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_empty, fifo_full, rlast_seen;
    logic          push, pop, tx_load, err_set;
    logic          rx_ready_nx, write_bus_req_nx, read_req_nx;

    assign rx_fire     = rx_valid & rx_ready;
    assign tx_fire     = tx_valid & tx_ready;
    assign words_total = (len[2:0] != 3'd0) ? 8'd1 : {1'b0, len[9:3]} + 8'd1;
    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == CW'(RFIFO_DEPTH));
    assign head        = mem[rd_ptr];

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) state <= IDLE;
        else              state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (rx_fire) next_state = (rx_data == 8'h01 || rx_data == 8'h02) ? HDR : ERR;
            HDR: begin
                if (timeout) next_state = ERR;
                else if (rx_fire && hdr_idx == 3'd5) next_state = is_read ? RREQ : WDATA;
            end
            WDATA: begin
                if (timeout) next_state = ERR;
                else if (rx_fire && byte_cnt == 3'd7 && word_cnt == words_total - 8'd1)
                    next_state = WBUS;
            end
            WBUS:    if (!busy) next_state = WACK;
            WACK:    if (tx_fire) next_state = IDLE;
            RREQ:    if (!busy) next_state = RDATA;
            RDATA:   if (rlast_seen && fifo_empty && (!tx_valid || tx_fire)) next_state = IDLE;
            ERR:     if (tx_fire) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Lookahead decode; the values are registered so every output leaves a flop.
    always_comb begin
        rx_ready_nx      = (next_state == IDLE) || (next_state == HDR) || (next_state == WDATA);
        write_bus_req_nx = (state == WBUS) && !busy;
        read_req_nx      = (state == RREQ) && !busy;
        push             = 1'b0;
        tx_load          = 1'b0;
        pop              = 1'b0;
        if (state == RDATA) begin
            push    = rdata_valid && !rlast_seen && !fifo_full;
            tx_load = (!tx_valid || tx_fire) && !fifo_empty;
            pop     = tx_load && (rd_byte == 3'd7);
        end
        err_set = ((next_state == ERR) && (state != ERR)) ||
                  ((state == RDATA) && rdata_valid && !rlast_seen && fifo_full);
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            rx_ready      <= 1'b0;
            tx_data       <= 8'd0;
            tx_valid      <= 1'b0;
            write_req     <= 1'b0;
            write_bus_req <= 1'b0;
            read_req      <= 1'b0;
            len           <= 10'd0;
            address       <= 32'd0;
            wdata         <= 64'd0;
            error         <= 1'b0;
            is_read       <= 1'b0;
            hdr_idx       <= 3'd0;
            byte_cnt      <= 3'd0;
            word_cnt      <= 8'd0;
            wbuf          <= 56'd0;
            rd_byte       <= 3'd0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rlast_seen    <= 1'b0;
        end else begin
            rx_ready      <= rx_ready_nx;
            write_bus_req <= write_bus_req_nx;
            read_req      <= read_req_nx;
            write_req     <= 1'b0;

            if (state == IDLE) begin
                hdr_idx  <= 3'd0;
                byte_cnt <= 3'd0;
                word_cnt <= 8'd0;
                if (rx_fire) is_read <= (rx_data == 8'h02);
            end

            // Header fields land directly in the len/address outputs.
            if (state == HDR && rx_fire) begin
                hdr_idx <= hdr_idx + 3'd1;
                case (hdr_idx)
                    3'd0:    len[7:0]       <= rx_data;
                    3'd1:    len[9:8]       <= rx_data[1:0];
                    3'd2:    address[7:0]   <= rx_data;
                    3'd3:    address[15:8]  <= rx_data;
                    3'd4:    address[23:16] <= rx_data;
                    3'd5:    address[31:24] <= rx_data;
                    default: ;
                endcase
            end

            // Bytes shift in from the top so byte 0 ends up in the low lane.
            if (state == WDATA && rx_fire) begin
                byte_cnt <= byte_cnt + 3'd1;
                wbuf     <= {rx_data, wbuf[55:8]};
                if (byte_cnt == 3'd7) begin
                    wdata     <= {rx_data, wbuf};
                    write_req <= 1'b1;
                    word_cnt  <= word_cnt + 8'd1;
                end
            end

            if (error_clr)    error <= 1'b0;
            else if (err_set) error <= 1'b1;

            if (state != WACK && next_state == WACK) begin
                tx_data  <= 8'hA5;
                tx_valid <= 1'b1;
            end else if (state != ERR && next_state == ERR) begin
                tx_data  <= 8'hEE;
                tx_valid <= 1'b1;
            end else if (tx_load) begin
                tx_data  <= head[{rd_byte, 3'b000} +: 8];
                tx_valid <= 1'b1;
                rd_byte  <= rd_byte + 3'd1;
            end else if (tx_fire) begin
                tx_valid <= 1'b0;
            end

            if (state != RDATA)            rlast_seen <= 1'b0;
            else if (rdata_valid && rlast) rlast_seen <= 1'b1;

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (push) mem[wr_ptr] <= rdata;
    end

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;

    // Counts idle cycles between accepted bytes while a command is being received.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET)                                        to_cnt <= '0;
        else if ((state == HDR || state == WDATA) && !rx_fire)   to_cnt <= to_cnt + TW'(1);
        else                                                     to_cnt <= '0;
    end

    assign timeout = (to_cnt == TW'(TIMEOUT_CYC));
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: doc/pmod_cmd_parser.md
Name: pmod_cmd_parser

Overview:
- Upstream command front-end for the AXI bus-master stage.
- Accepts a byte stream from the Pmod link receiver and parses write/read commands.
- Drives write_req / write_bus_req / read_req, len, address and wdata into the bus-master stage.
- Returns read data and write acks to the host as a byte stream.

Parameters:
- RFIFO_DEPTH, 16, depth in 64-bit words of the read-return FIFO (power of 2, 4..128).
- TIMEOUT_CYC, 1000000, inter-byte timeout in clocks. Used only with CMD_TIMEOUT_EN.

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESET  in  1  asynchronous, active-high reset.
- rx_data  in  8  host byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte accepted when rx_valid&rx_ready.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts tx byte.
- write_req  out  1  push wdata into bus-master write buffer (1-cycle pulse).
- write_bus_req  out  1  start AXI write burst (1-cycle pulse).
- read_req  out  1  start AXI read burst (1-cycle pulse).
- busy  in  1  bus-master stall indication.
- len  out  10  length code (1,2,4,6, or 8n).
- address  out  32  byte address.
- wdata  out  64  write word.
- rdata  in  64  read word.
- rdata_valid  in  1  rdata updated this cycle (integration ties to RVALID&RREADY, registered).
- rlast  in  1  last read word.
- error  out  1  sticky error flag.
- error_clr  in  1  clears error.

Behaviour:
- Reset (async, active-high): all outputs 0, FSM=IDLE, FIFO empty, byte counters 0.
- Command header, 7 bytes, little-endian:
  - byte 0: opcode. 0x01 = write, 0x02 = read.
  - bytes 1-2: len. Only bits [9:0] are kept.
  - bytes 3-6: address.
- Word count W = 1 if len[2:0]!=0, else len[9:3]+1.
- Write payload: 8*W bytes. Byte k of a word maps to wdata[8k+7:8k]. Sub-word writes place data in the lane given by address[2:0].
- States:
  - IDLE: rx_ready=1. Opcode 0x01/0x02 -> HDR. Any other opcode -> ERR.
  - HDR: rx_ready=1. Collects 6 bytes, then goes to WDATA (write) or RREQ (read).
  - WDATA: rx_ready=1. On every 8th byte, assemble wdata and pulse write_req in the cycle after that byte. After W words -> WBUS. wdata holds the last word.
  - WBUS: rx_ready=0. Wait until busy=0, pulse write_bus_req for 1 cycle, go to WACK.
  - WACK: present tx_data=0xA5, tx_valid=1. On tx_ready go to IDLE.
  - RREQ: wait until busy=0, pulse read_req, go to RDATA.
  - RDATA: rx_ready=0.
    - Each rdata_valid pushes rdata into the FIFO.
    - The FIFO head is serialized LSB byte first, one byte per tx handshake.
    - Once rlast has been seen and the FIFO has drained -> IDLE.
  - ERR: present tx_data=0xEE. On tx_ready -> IDLE. Sets error.
- len/address outputs are valid from HDR completion until return to IDLE.
- Pulses:
  - write_req, write_bus_req and read_req are never asserted in the same cycle.
  - write_bus_req and read_req are only issued when busy=0.
- FIFO full plus rdata_valid: the word is dropped and error is set. The bus side has no backpressure. The FSM still exits on rlast.
- rdata_valid while not in RDATA: ignored.
- tx_valid, once asserted, holds with stable tx_data until tx_ready.
- error_clr has priority over a simultaneous error set. The error is lost in that case.
- Counter wrap:
  - The 3-bit byte-in-word counter wraps 7->0.
  - The word counter is 8 bits; max W=128.

Optional Feature:
- Macro CMD_TIMEOUT_EN.
- Defined:
  - A counter runs in HDR and WDATA, and resets on each accepted byte.
  - Reaching TIMEOUT_CYC aborts to ERR without issuing any bus request.
  - Any write_req pulses already issued stay issued.
- Undefined: no counter. The FSM waits for bytes indefinitely.

Test Plan:
- Write, single byte:
  - Stimulus: 01 01 00 10 00 00 40, then 8 bytes with 0x5A in lane 0.
  - Required: one write_req with wdata=0x...5A; then write_bus_req with len=1, address=0x40000010; then tx byte 0xA5.
- Burst write:
  - Stimulus: len=0x018 (W=4), 32 bytes.
  - Required: four write_req pulses, words in order; write_bus_req only after the 4th; busy held high 5 cycles delays write_bus_req exactly 5 cycles.
- Burst read:
  - Stimulus: len=0x008 (W=2); bus returns rdata 0x0807060504030201, then 0x100F0E0D0C0B0A09 with rlast.
  - Required: tx bytes 01..10 in order; FSM back to IDLE.
- Read overflow:
  - Stimulus: RFIFO_DEPTH=4, W=8, tx_ready=0 during the burst.
  - Required: first 4 words returned; error=1; returns to IDLE after the drain.
- Bad opcode:
  - Stimulus: byte 0x7F.
  - Required: tx 0xEE, error=1; error_clr clears it; next valid command executes normally.
- Async reset mid-WDATA (and, with CMD_TIMEOUT_EN, a stalled header):
  - Reset mid-WDATA: outputs 0 immediately; no write_bus_req afterwards.
  - Header stalled for TIMEOUT_CYC: tx 0xEE, no bus request issued.
